cpu_out_serializer: RTL and testbench

Downstream consumer of the CPU's output port (outFlag/out).
- Captures each 36-bit value the CPU emits into a small FIFO.
- Drains the FIFO as a byte stream, least significant byte first, over a valid/ready handshake toward a host link (UART/debug bridge).
- Decouples CPU OUT bursts from a slow byte sink and flags lost words.

---
 rtl/cpu_io_pkg.sv | 17 +
 rtl/io_sync_fifo.sv | 64 ++++++
 rtl/cpu_out_serializer.sv | 127 ++++++++++++
 tb/tb_cpu_out_serializer.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_io_pkg.sv
// Shared constants and types for the CPU output serializer.
// Build option: CPU_OUT_FRAME_EN (consumed by cpu_out_serializer).
package cpu_io_pkg;

   localparam int CPU_WIDTH  = 36;
   localparam int BYTE_WIDTH = 8;

   function automatic int calc_nbytes(input int width, input int byte_width);
      return (width + byte_width - 1) / byte_width;
   endfunction

   localparam int         NBYTES       = calc_nbytes(CPU_WIDTH, BYTE_WIDTH);
   localparam logic [7:0] FRAME_HEADER = 8'hA5;

   typedef enum logic {IDLE, SEND} ser_state_e;

endpackage

// File: rtl/io_sync_fifo.sv
// Synchronous FIFO with registered occupancy count and sticky overflow flag.
// A push while full is dropped even if a pop happens on the same edge.
module io_sync_fifo
   import cpu_io_pkg::*;
#(
   parameter int WIDTH    = 36,
   parameter int DEPTH    = 8,
   parameter int PTRWIDTH = 3
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                i_push,
   input  logic [WIDTH-1:0]    i_data,
   input  logic                i_pop,
   output logic [WIDTH-1:0]    o_head,
   output logic [PTRWIDTH:0]   o_count,
   output logic                o_overflow
);

   localparam int CW = PTRWIDTH + 1;

   logic [WIDTH-1:0]    r_mem [DEPTH];
   logic [PTRWIDTH-1:0] r_wr_ptr;
   logic [PTRWIDTH-1:0] r_rd_ptr;
   logic [CW-1:0]       r_count;
   logic                r_overflow;

   logic w_full;
   logic w_do_push;
   logic w_do_pop;

   assign w_full    = (r_count == CW'(DEPTH));
   assign w_do_push = i_push & ~w_full;
   assign w_do_pop  = i_pop & (r_count != '0);

   always_ff @(posedge clock) begin
      // NOTE: sequential state is written with non-blocking assignments only.
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTRWIDTH'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTRWIDTH'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (i_push && w_full) r_overflow <= 1'b1;
      end
   end

   // NOTE: storage is not reset; an entry is only read after it has been written.
   always_ff @(posedge clock) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_head     = r_mem[r_rd_ptr];
   assign o_count    = r_count;
   assign o_overflow = r_overflow;

endmodule

// File: rtl/cpu_out_serializer.sv
// Buffers CPU OUT words and streams them LSB-first as bytes over valid/ready.
// Build option: define CPU_OUT_FRAME_EN to prefix each word with header byte 0xA5.
module cpu_out_serializer
   import cpu_io_pkg::*;
#(
   parameter int WIDTH     = 36,
   parameter int DEPTH     = 8,
   parameter int PTRWIDTH  = 3,
   parameter int BYTEWIDTH = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 outFlag,
   input  logic [WIDTH-1:0]     out,
   input  logic                 byteReady,
   output logic                 byteValid,
   output logic [BYTEWIDTH-1:0] byteOut,
   output logic                 byteLast,
   output logic [PTRWIDTH:0]    fifoCount,
   output logic                 overflow
);

   localparam int NB = calc_nbytes(WIDTH, BYTEWIDTH);
   localparam int SW = NB * BYTEWIDTH;
`ifdef CPU_OUT_FRAME_EN
   localparam int LAST_IDX = NB;
`else
   localparam int LAST_IDX = NB - 1;
`endif
   localparam int IDXW = $clog2(LAST_IDX + 1);

   ser_state_e       r_state;
   logic [SW-1:0]    r_shift;
   logic [IDXW-1:0]  r_idx;

   ser_state_e       w_state_nxt;
   logic [SW-1:0]    w_shift_nxt;
   logic [IDXW-1:0]  w_idx_nxt;
   logic             w_pop;
   logic [WIDTH-1:0] w_head;
   logic [SW-1:0]    w_head_ext;
   logic [PTRWIDTH:0] w_count;
   logic             w_overflow;
   logic             w_last;
   logic             w_hdr;

   io_sync_fifo #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .PTRWIDTH (PTRWIDTH)
   ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .i_push     (outFlag),
      .i_data     (out),
      .i_pop      (w_pop),
      .o_head     (w_head),
      .o_count    (w_count),
      .o_overflow (w_overflow)
   );

   assign w_head_ext = SW'(w_head);
   assign w_last     = (r_idx == IDXW'(LAST_IDX));
`ifdef CPU_OUT_FRAME_EN
   assign w_hdr = (r_idx == '0);
`else
   assign w_hdr = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
         r_shift <= '0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_shift <= w_shift_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   always_comb begin
      // NOTE: every combinational output is defaulted first so no latch is inferred.
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_idx_nxt   = r_idx;
      w_pop       = 1'b0;
      byteValid   = 1'b0;
      byteOut     = '0;
      byteLast    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_count != '0) begin
               w_pop       = 1'b1;
               w_shift_nxt = w_head_ext;
               w_idx_nxt   = '0;
               w_state_nxt = SEND;
            end
         end
         SEND: begin
            byteValid = 1'b1;
            byteOut   = w_hdr ? BYTEWIDTH'(FRAME_HEADER) : r_shift[BYTEWIDTH-1:0];
            byteLast  = w_last;
            if (byteReady) begin
               if (w_last) begin
                  // Chain straight into the next word so there is no idle bubble.
                  if (w_count != '0) begin
                     w_pop       = 1'b1;
                     w_shift_nxt = w_head_ext;
                     w_idx_nxt   = '0;
                  end else begin
                     w_state_nxt = IDLE;
                  end
               end else begin
                  w_idx_nxt = r_idx + IDXW'(1);
                  if (!w_hdr) w_shift_nxt = r_shift >> BYTEWIDTH;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign fifoCount = w_count;
   assign overflow  = w_overflow;

endmodule

// File: tb/tb_cpu_out_serializer.sv
// Directed self-checking bench for cpu_out_serializer (default and CPU_OUT_FRAME_EN builds).
module tb_cpu_out_serializer;

   localparam int NB = 5;
`ifdef CPU_OUT_FRAME_EN
   localparam int LEN = NB + 1;
`else
   localparam int LEN = NB;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        outFlag = 1'b0;
   logic [35:0] out = '0;
   logic        byteReady = 1'b0;
   logic        byteValid;
   logic [7:0]  byteOut;
   logic        byteLast;
   logic [3:0]  fifoCount;
   logic        overflow;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;

   logic [8:0] rx_q[$];
   int         rx_cyc[$];
   logic [8:0] exp_q[$];

   cpu_out_serializer dut (
      .clock     (clock),
      .reset     (reset),
      .outFlag   (outFlag),
      .out       (out),
      .byteReady (byteReady),
      .byteValid (byteValid),
      .byteOut   (byteOut),
      .byteLast  (byteLast),
      .fifoCount (fifoCount),
      .overflow  (overflow)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // A byte presented with ready high at the negedge is accepted on the next rising edge.
   always @(negedge clock) begin
      if (byteValid === 1'b1 && byteReady === 1'b1) begin
         rx_q.push_back({byteLast, byteOut});
         rx_cyc.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_queues();
      rx_q.delete();
      rx_cyc.delete();
      exp_q.delete();
   endtask

   // Reference stream for one word: optional header, then LSB-first zero-extended bytes.
   task automatic append_exp(input logic [35:0] w);
      logic [39:0] v;
      v = {4'h0, w};
`ifdef CPU_OUT_FRAME_EN
      exp_q.push_back({1'b0, 8'hA5});
`endif
      for (int i = 0; i < NB; i++) exp_q.push_back({(i == NB - 1), v[8*i +: 8]});
   endtask

   task automatic test_reset();
      reset = 1'b1;
      outFlag = 1'b1;
      out = 36'h1_2345_6789;
      byteReady = 1'b1;
      for (int c = 0; c < 2; c++) begin
         tick();
         tests_run++;
         if ({byteValid, byteOut, byteLast, fifoCount, overflow} !== 15'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs cycle %0d: got v=%b b=%h l=%b cnt=%0d ovf=%b, want all 0",
                     c, byteValid, byteOut, byteLast, fifoCount, overflow);
         end
      end
      reset = 1'b0;
      outFlag = 1'b0;
      tick();
      tick();
      tests_run++;
      if (fifoCount !== 4'd0) begin
         tests_failed++;
         $display("FAIL reset_no_push: fifoCount=%0d, want 0", fifoCount);
      end
      tests_run++;
      if (byteValid !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_idle: byteValid=%b, want 0", byteValid);
      end
   endtask

   task automatic test_single();
      clear_queues();
      append_exp(36'd13);
      byteReady = 1'b1;
      outFlag = 1'b1;
      out = 36'd13;
      tick();
      outFlag = 1'b0;
      tests_run++;
      if (fifoCount !== 4'd1 || byteValid !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_push: cnt=%0d valid=%b, want cnt=1 valid=0", fifoCount, byteValid);
      end
      tick();
      tests_run++;
      if (byteValid !== 1'b1 || byteOut !== exp_q[0][7:0] || fifoCount !== 4'd0) begin
         tests_failed++;
         $display("FAIL single_latency: valid=%b byte=%h cnt=%0d, want valid=1 byte=%h cnt=0",
                  byteValid, byteOut, fifoCount, exp_q[0][7:0]);
      end
      for (int k = 0; k < 100 && rx_q.size() < exp_q.size(); k++) tick();
      tests_run++;
      if (rx_q.size() != exp_q.size()) begin
         tests_failed++;
         $display("FAIL single_count: got %0d bytes, want %0d", rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         tests_run++;
         if (rx_q[i] !== exp_q[i]) begin
            tests_failed++;
            $display("FAIL single_byte[%0d]: got last=%b %h, want last=%b %h",
                     i, rx_q[i][8], rx_q[i][7:0], exp_q[i][8], exp_q[i][7:0]);
         end
      end
      tick();
      tests_run++;
      if (byteValid !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_idle: byteValid=%b, want 0", byteValid);
      end
   endtask

   task automatic test_back_to_back();
      logic [35:0] words [3];
      int peak;
      int gaps;
      words = '{36'd13, 36'd2, 36'd1};
      clear_queues();
      peak = 0;
      gaps = 0;
      byteReady = 1'b1;
      for (int w = 0; w < 3; w++) begin
         append_exp(words[w]);
         outFlag = 1'b1;
         out = words[w];
         tick();
         if (int'(fifoCount) > peak) peak = int'(fifoCount);
      end
      outFlag = 1'b0;
      for (int k = 0; k < 200 && rx_q.size() < exp_q.size(); k++) begin
         tick();
         if (int'(fifoCount) > peak) peak = int'(fifoCount);
      end
      tests_run++;
      if (peak != 2) begin
         tests_failed++;
         $display("FAIL b2b_peak: fifoCount peak=%0d, want 2", peak);
      end
      tests_run++;
      if (rx_q.size() != exp_q.size()) begin
         tests_failed++;
         $display("FAIL b2b_count: got %0d bytes, want %0d", rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         tests_run++;
         if (rx_q[i] !== exp_q[i]) begin
            tests_failed++;
            $display("FAIL b2b_byte[%0d]: got last=%b %h, want last=%b %h",
                     i, rx_q[i][8], rx_q[i][7:0], exp_q[i][8], exp_q[i][7:0]);
         end
         if (i > 0 && rx_cyc[i] != rx_cyc[i-1] + 1) gaps++;
      end
      tests_run++;
      if (gaps != 0) begin
         tests_failed++;
         $display("FAIL b2b_gaps: got %0d idle cycles inside the stream, want 0", gaps);
      end
   endtask

   task automatic test_stall();
      clear_queues();
      append_exp(36'h9_8765_4321);
      byteReady = 1'b0;
      outFlag = 1'b1;
      out = 36'h9_8765_4321;
      tick();
      outFlag = 1'b0;
      tick();
      tests_run++;
      if (byteValid !== 1'b1 || byteOut !== exp_q[0][7:0]) begin
         tests_failed++;
         $display("FAIL stall_first: valid=%b byte=%h, want valid=1 byte=%h",
                  byteValid, byteOut, exp_q[0][7:0]);
      end
      byteReady = 1'b1;
      tick();
      tick();
      byteReady = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         tests_run++;
         if ({byteValid, byteLast, byteOut} !== {1'b1, exp_q[2][8], exp_q[2][7:0]}) begin
            tests_failed++;
            $display("FAIL stall_hold cycle %0d: valid=%b last=%b byte=%h, want valid=1 last=%b byte=%h",
                     c, byteValid, byteLast, byteOut, exp_q[2][8], exp_q[2][7:0]);
         end
      end
      tests_run++;
      if (rx_q.size() != 2) begin
         tests_failed++;
         $display("FAIL stall_accepted: got %0d bytes during stall, want 2", rx_q.size());
      end
      byteReady = 1'b1;
      for (int k = 0; k < 100 && rx_q.size() < exp_q.size(); k++) tick();
      for (int i = 0; i < exp_q.size(); i++) begin
         tests_run++;
         if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
            tests_failed++;
            $display("FAIL stall_byte[%0d]: got %h, want %h",
                     i, (i < rx_q.size()) ? rx_q[i] : 9'h1FF, exp_q[i]);
         end
      end
   endtask

   task automatic test_overflow();
      int ovf_drop;
      clear_queues();
      byteReady = 1'b0;
      ovf_drop = 0;
      // The first word moves into the shift register, so the FIFO fills on the 9th push
      // and the 10th push is the one dropped.
      for (int i = 0; i < 10; i++) begin
         outFlag = 1'b1;
         out = 36'(i) * 36'h1_1111_1111;
         if (i < 9) append_exp(36'(i) * 36'h1_1111_1111);
         tick();
         if (i == 8) begin
            tests_run++;
            if (fifoCount !== 4'd8 || overflow !== 1'b0) begin
               tests_failed++;
               $display("FAIL ovf_full: cnt=%0d ovf=%b, want cnt=8 ovf=0", fifoCount, overflow);
            end
         end
      end
      outFlag = 1'b0;
      tests_run++;
      if (fifoCount !== 4'd8 || overflow !== 1'b1) begin
         tests_failed++;
         $display("FAIL ovf_drop: cnt=%0d ovf=%b, want cnt=8 ovf=1", fifoCount, overflow);
      end
      byteReady = 1'b1;
      for (int k = 0; k < 400 && rx_q.size() < exp_q.size(); k++) begin
         tick();
         if (overflow !== 1'b1) ovf_drop++;
      end
      tests_run++;
      if (ovf_drop != 0) begin
         tests_failed++;
         $display("FAIL ovf_sticky: overflow low in %0d drain cycles, want 0", ovf_drop);
      end
      tests_run++;
      if (rx_q.size() != exp_q.size()) begin
         tests_failed++;
         $display("FAIL ovf_count: got %0d bytes, want %0d", rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         tests_run++;
         if (rx_q[i] !== exp_q[i]) begin
            tests_failed++;
            $display("FAIL ovf_byte[%0d]: got %h, want %h", i, rx_q[i], exp_q[i]);
         end
      end
      tick();
      tests_run++;
      if (fifoCount !== 4'd0 || overflow !== 1'b1 || byteValid !== 1'b0) begin
         tests_failed++;
         $display("FAIL ovf_after: cnt=%0d ovf=%b valid=%b, want cnt=0 ovf=1 valid=0",
                  fifoCount, overflow, byteValid);
      end
   endtask

   task automatic test_reset_mid_word();
      int stray;
      stray = 0;
      byteReady = 1'b0;
      outFlag = 1'b1;
      out = 36'h1_2345_6789;
      tick();
      outFlag = 1'b0;
      tick();
      tests_run++;
      if (byteValid !== 1'b1) begin
         tests_failed++;
         $display("FAIL mid_valid: byteValid=%b, want 1", byteValid);
      end
      reset = 1'b1;
      tick();
      tests_run++;
      if ({byteValid, byteOut, byteLast, fifoCount, overflow} !== 15'h0) begin
         tests_failed++;
         $display("FAIL mid_reset: v=%b b=%h l=%b cnt=%0d ovf=%b, want all 0",
                  byteValid, byteOut, byteLast, fifoCount, overflow);
      end
      reset = 1'b0;
      byteReady = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (byteValid !== 1'b0) stray++;
      end
      tests_run++;
      if (stray != 0) begin
         tests_failed++;
         $display("FAIL mid_abandon: byteValid high %0d cycles after reset, want 0", stray);
      end
   endtask

`ifdef CPU_OUT_FRAME_EN
   task automatic test_frame();
      logic [8:0] fr [6];
      fr = '{9'h0A5, 9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF, 9'h10F};
      clear_queues();
      byteReady = 1'b1;
      outFlag = 1'b1;
      out = 36'hF_FFFF_FFFF;
      tick();
      outFlag = 1'b0;
      for (int k = 0; k < 100 && rx_q.size() < 6; k++) tick();
      tests_run++;
      if (rx_q.size() != 6) begin
         tests_failed++;
         $display("FAIL frame_count: got %0d bytes, want 6", rx_q.size());
      end
      for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
         tests_run++;
         if (rx_q[i] !== fr[i]) begin
            tests_failed++;
            $display("FAIL frame_byte[%0d]: got last=%b %h, want last=%b %h",
                     i, rx_q[i][8], rx_q[i][7:0], fr[i][8], fr[i][7:0]);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_overflow();
      test_reset_mid_word();
`ifdef CPU_OUT_FRAME_EN
      test_frame();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit (%0d tests run, %0d failed)",
               tests_run, tests_failed);
      $fatal(1, "watchdog");
   end

endmodule
